async_fifo_wr_frame_ctrl: RTL and testbench

//  Write-side controller for the Ethernet RX async FIFO (dual-port BRAM, depth 2**SIZE, wr_clk domain).

---
 rtl/async_fifo_pkg.sv | 24 ++
 rtl/gray_ptr_sync.sv | 32 +++
 rtl/async_fifo_wr_frame_ctrl.sv | 119 +++++++++++
 tb/tb_async_fifo_wr_frame_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared types and pointer-encoding helpers for the Ethernet RX async FIFO.
// Helpers work on 32-bit vectors; callers zero-extend and truncate to their pointer width.
package async_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      DROP  = 2'd2
   } wr_state_t;

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Synchroniser for a Gray-coded pointer from a foreign clock domain.
// The binary conversion is taken only from the last stage.
module gray_ptr_sync
   import async_fifo_pkg::*;
#(
   parameter int unsigned W      = 5,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] gray_in,
   output logic [W-1:0] bin_c
);

   logic [W-1:0] sync_q [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(STAGES); i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= gray_in;
         for (int i = 1; i < int'(STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign bin_c = W'(gray2bin(32'(sync_q[STAGES-1])));

endmodule

// File: rtl/async_fifo_wr_frame_ctrl.sv
// Write-side frame controller for the RX async FIFO: writes beats, commits good frames,
// rewinds errored or overflowing frames so the read side only ever sees whole good frames.
module async_fifo_wr_frame_ctrl
   import async_fifo_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned SIZE         = 8,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned AFULL_MARGIN = 16
) (
   input  logic              wr_clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  s_data,
   input  logic              s_valid,
   input  logic              s_last,
   input  logic              s_error,
   output logic [WIDTH-1:0]  mem_data_in,
   output logic              mem_wr_en,
   output logic [SIZE:0]     mem_wrt_ptr,
   input  logic [SIZE:0]     rd_ptr_gray,
   output logic [SIZE:0]     wr_ptr_gray,
   output logic              full,
   output logic              almost_full,
   output logic [SIZE:0]     level,
   output logic              frame_drop,
   output logic [15:0]       drop_count
);

   localparam int unsigned PTR_W = SIZE + 1;
   localparam logic [PTR_W-1:0] DEPTH = {1'b1, {SIZE{1'b0}}};

   wr_state_t        state_q, state_d;
   logic [PTR_W-1:0] wp_q, wp_d;
   logic [PTR_W-1:0] cp_q, cp_d;
   logic [PTR_W-1:0] rp;
   logic [PTR_W-1:0] used;
   logic [PTR_W-1:0] free;
   logic             drop_pulse;

   gray_ptr_sync #(
      .W      (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_rd_sync (
      .clk     (wr_clk),
      .rst_n   (rst_n),
      .gray_in (rd_ptr_gray),
      .bin_c   (rp)
   );

   // Flags follow the working pointer for full, the committed pointer for level.
   assign used        = wp_q - rp;
   assign free        = DEPTH - used;
   assign full        = (used == DEPTH);
   assign almost_full = (32'(free) <= 32'(AFULL_MARGIN));
   assign level       = cp_q - rp;
   assign mem_data_in = s_data;
   assign mem_wrt_ptr = wp_q;

   // Next-state, pointer update and write strobe.
   always_comb begin
      state_d    = state_q;
      wp_d       = wp_q;
      cp_d       = cp_q;
      mem_wr_en  = 1'b0;
      drop_pulse = 1'b0;
      if (s_valid) begin
         case (state_q)
            IDLE, FRAME: begin
               if (full) begin
                  wp_d       = cp_q;
                  drop_pulse = 1'b1;
                  state_d    = s_last ? IDLE : DROP;
               end else begin
                  mem_wr_en = 1'b1;
                  wp_d      = wp_q + PTR_W'(1);
                  if (!s_last) begin
                     state_d = FRAME;
                  end else if (s_error) begin
                     wp_d       = cp_q;
                     drop_pulse = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     cp_d    = wp_q + PTR_W'(1);
                     state_d = IDLE;
                  end
               end
            end
            DROP: begin
               if (s_last) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Published Gray pointer trails cp by one register so it only moves in whole frames.
   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wp_q        <= '0;
         cp_q        <= '0;
         wr_ptr_gray <= '0;
         frame_drop  <= 1'b0;
         drop_count  <= '0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         cp_q        <= cp_d;
         wr_ptr_gray <= PTR_W'(bin2gray(32'(cp_q)));
         frame_drop  <= drop_pulse;
         if (drop_pulse && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_async_fifo_wr_frame_ctrl.sv
// Directed bench for the RX FIFO write-side frame controller (SIZE=4, depth 16).
module tb_async_fifo_wr_frame_ctrl;

   logic        wr_clk;
   logic        rst_n;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_error;
   logic [7:0]  mem_data_in;
   logic        mem_wr_en;
   logic [4:0]  mem_wrt_ptr;
   logic [4:0]  rd_ptr_gray;
   logic [4:0]  wr_ptr_gray;
   logic        full;
   logic        almost_full;
   logic [4:0]  level;
   logic        frame_drop;
   logic [15:0] drop_count;

   int errors = 0;
   int checks = 0;

   async_fifo_wr_frame_ctrl #(
      .WIDTH        (8),
      .SIZE         (4),
      .SYNC_STAGES  (2),
      .AFULL_MARGIN (4)
   ) dut (
      .wr_clk      (wr_clk),
      .rst_n       (rst_n),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_error     (s_error),
      .mem_data_in (mem_data_in),
      .mem_wr_en   (mem_wr_en),
      .mem_wrt_ptr (mem_wrt_ptr),
      .rd_ptr_gray (rd_ptr_gray),
      .wr_ptr_gray (wr_ptr_gray),
      .full        (full),
      .almost_full (almost_full),
      .level       (level),
      .frame_drop  (frame_drop),
      .drop_count  (drop_count)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic last, input logic err);
      @(negedge wr_clk);
      s_data  = d;
      s_valid = 1'b1;
      s_last  = last;
      s_error = err;
      #1;
   endtask

   task automatic idle();
      @(negedge wr_clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_error = 1'b0;
      #1;
   endtask

   initial begin
      rst_n       = 1'b1;
      s_data      = '0;
      s_valid     = 1'b0;
      s_last      = 1'b0;
      s_error     = 1'b0;
      rd_ptr_gray = '0;

      // 1: asynchronous reset asserted mid-cycle
      @(posedge wr_clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_wr_ptr_gray", 32'(wr_ptr_gray), 32'h0);
      chk("rst_wrt_ptr",     32'(mem_wrt_ptr), 32'h0);
      chk("rst_full",        32'(full),        32'h0);
      chk("rst_afull",       32'(almost_full), 32'h0);
      chk("rst_level",       32'(level),       32'h0);
      chk("rst_frame_drop",  32'(frame_drop),  32'h0);
      chk("rst_drop_count",  32'(drop_count),  32'h0);
      chk("rst_wr_en",       32'(mem_wr_en),   32'h0);
      @(negedge wr_clk);
      rst_n = 1'b1;

      // 2: good three-beat frame
      send(8'hA1, 1'b0, 1'b0);
      chk("t2_wr_en0", 32'(mem_wr_en),   32'h1);
      chk("t2_addr0",  32'(mem_wrt_ptr), 32'h0);
      chk("t2_data0",  32'(mem_data_in), 32'hA1);
      send(8'hA2, 1'b0, 1'b0);
      chk("t2_addr1",  32'(mem_wrt_ptr), 32'h1);
      send(8'hA3, 1'b1, 1'b0);
      chk("t2_addr2",  32'(mem_wrt_ptr), 32'h2);
      chk("t2_wr_en2", 32'(mem_wr_en),   32'h1);
      idle();
      chk("t2_wr_en_idle", 32'(mem_wr_en),   32'h0);
      chk("t2_level",      32'(level),       32'h3);
      chk("t2_gray_1clk",  32'(wr_ptr_gray), 32'h0);
      chk("t2_wp",         32'(mem_wrt_ptr), 32'h3);
      idle();
      chk("t2_gray_2clk",  32'(wr_ptr_gray), 32'h02);

      // 3: five-beat frame with error on last beat
      for (int i = 0; i < 5; i++) begin
         send(8'h10 + 8'(i), i == 4, i == 4);
         chk("t3_wr_en", 32'(mem_wr_en),   32'h1);
         chk("t3_addr",  32'(mem_wrt_ptr), 32'(3 + i));
      end
      idle();
      chk("t3_wp_rewind",  32'(mem_wrt_ptr), 32'h3);
      chk("t3_drop_pulse", 32'(frame_drop),  32'h1);
      chk("t3_drop_count", 32'(drop_count),  32'h1);
      chk("t3_level",      32'(level),       32'h3);
      idle();
      chk("t3_drop_end",   32'(frame_drop),  32'h0);
      chk("t3_gray_hold",  32'(wr_ptr_gray), 32'h02);

      // Start the overflow tests from a clean, empty FIFO
      rst_n = 1'b0;
      #1;
      @(negedge wr_clk);
      rst_n = 1'b1;

      // 4a: 17-beat frame from empty, last on the 17th beat
      for (int i = 0; i < 17; i++) begin
         send(8'(i), i == 16, 1'b0);
         chk("t4_full",  32'(full),        32'(i == 16));
         chk("t4_afull", 32'(almost_full), 32'(i >= 12));
         chk("t4_wr_en", 32'(mem_wr_en),   32'(i < 16));
         if (i < 16) chk("t4_addr", 32'(mem_wrt_ptr), 32'(i));
      end
      idle();
      chk("t4_wp",         32'(mem_wrt_ptr), 32'h0);
      chk("t4_drop_pulse", 32'(frame_drop),  32'h1);
      chk("t4_drop_count", 32'(drop_count),  32'h1);
      chk("t4_level",      32'(level),       32'h0);
      chk("t4_full_after", 32'(full),        32'h0);
      chk("t4_gray",       32'(wr_ptr_gray), 32'h0);

      // 4b: 18-beat frame, last beat arrives while discarding
      for (int i = 0; i < 18; i++) begin
         send(8'h40 + 8'(i), i == 17, 1'b0);
         chk("t4b_wr_en", 32'(mem_wr_en), 32'(i < 16));
         if (i == 17) begin
            chk("t4b_wp_drop",    32'(mem_wrt_ptr), 32'h0);
            chk("t4b_drop_pulse", 32'(frame_drop),  32'h1);
         end
      end
      idle();
      chk("t4b_drop_once",  32'(drop_count),  32'h2);
      chk("t4b_drop_end",   32'(frame_drop),  32'h0);
      chk("t4b_wp",         32'(mem_wrt_ptr), 32'h0);

      // 5: fill exactly 16 and commit, then read side frees it, then wrap
      for (int i = 0; i < 16; i++) begin
         send(8'hA0 + 8'(i), i == 15, 1'b0);
         chk("t5_wr_en", 32'(mem_wr_en),   32'h1);
         chk("t5_addr",  32'(mem_wrt_ptr), 32'(i));
      end
      idle();
      chk("t5_full",  32'(full),        32'h1);
      chk("t5_level", 32'(level),       32'h10);
      chk("t5_wp",    32'(mem_wrt_ptr), 32'h10);
      idle();
      chk("t5_gray16", 32'(wr_ptr_gray), 32'h18);
      rd_ptr_gray = 5'b11000;
      idle();
      chk("t5_full_sync1", 32'(full), 32'h1);
      idle();
      idle();
      chk("t5_full_fall", 32'(full),  32'h0);
      chk("t5_empty",     32'(level), 32'h0);
      for (int i = 0; i < 4; i++) begin
         send(8'hC0 + 8'(i), i == 3, 1'b0);
         chk("t5_wrap_wr_en", 32'(mem_wr_en),        32'h1);
         chk("t5_wrap_addr",  32'(mem_wrt_ptr[3:0]), 32'(i));
      end
      idle();
      idle();
      chk("t5_cp20_gray", 32'(wr_ptr_gray), 32'h1E);
      chk("t5_level4",    32'(level),       32'h4);
      chk("t5_wp20",      32'(mem_wrt_ptr), 32'h14);

      // 6: reset in the middle of a frame
      send(8'hE0, 1'b0, 1'b0);
      send(8'hE1, 1'b0, 1'b0);
      @(negedge wr_clk);
      rst_n       = 1'b0;
      s_valid     = 1'b0;
      rd_ptr_gray = '0;
      #1;
      chk("t6_wp",         32'(mem_wrt_ptr), 32'h0);
      chk("t6_drop_count", 32'(drop_count),  32'h0);
      chk("t6_level",      32'(level),       32'h0);
      chk("t6_gray",       32'(wr_ptr_gray), 32'h0);
      @(negedge wr_clk);
      rst_n = 1'b1;
      send(8'hB0, 1'b0, 1'b0);
      chk("t6_addr0", 32'(mem_wrt_ptr), 32'h0);
      send(8'hB1, 1'b1, 1'b0);
      chk("t6_addr1", 32'(mem_wrt_ptr), 32'h1);
      idle();
      idle();
      chk("t6_commit_gray", 32'(wr_ptr_gray), 32'h03);
      chk("t6_level",       32'(level),       32'h2);
      chk("t6_no_drop",     32'(drop_count),  32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
